sp_ram_ctrl: RTL
================

Name: sp_ram_ctrl

Overview:
Parametrised single-port synchronous RAM with a request/response handshake, byte-lane write strobes, address validation, and a hardware clear sequence after reset. It generalises the fixed 16-word, 32-bit control-register BRAM. It serves as the storage element for control/status register banks and small scratch buffers on the core bus. Memory is inferred in RTL (no vendor IP).

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8, min 8
DEPTH, 16, number of words; min 2, need not be a power of 2
ADDR_W, 32, width of the byte address input

Ports:
clk  input  1  clock; all logic on rising edge
rstn  input  1  asynchronous active-low reset
req  input  1  request valid
ready  output  1  block can accept a request this cycle
we  input  1  1 = write, 0 = read; sampled when req && ready
wstrb  input  DATA_W/8  byte-lane write enables; ignored on reads
addr  input  ADDR_W  byte address
wdata  input  DATA_W  write data
rvalid  output  1  one-cycle response pulse, one per accepted request
rdata  output  DATA_W  read data; qualified by rvalid
err  output  1  request rejected; qualified by rvalid
init_done  output  1  clear sequence complete; stays 1 until next reset

Behaviour:
- Derived constants: NB = DATA_W/8; OFF_W = clog2(NB) (0 when NB=1); IDX_W = max(1, clog2(DEPTH)).
- Reset (rstn low, asynchronous): state is CLEAR, clear counter is 0, ready=0, rvalid=0, rdata=0, err=0, init_done=0. Any in-flight response is dropped.
- CLEAR state: writes all-zero to word[cnt] each cycle, for cnt = 0..DEPTH-1. ready=0. After writing word DEPTH-1, go to IDLE next cycle and set init_done=1. Duration is exactly DEPTH cycles after rstn deasserts. req is ignored during CLEAR; no response is generated.
- IDLE state: ready=1 continuously. A request is accepted on any cycle with req=1. Back-to-back requests every cycle are sustained.
- Address check on the accepted request:
  - misaligned if addr[OFF_W-1:0] != 0;
  - out of range if (addr >> OFF_W) >= DEPTH.
  - Either condition makes the request an error.
- Valid write: for each lane i with wstrb[i]=1, word[idx][8i+7:8i] <= wdata lane i. Other lanes are unchanged. wstrb=0 is legal and leaves memory untouched.
- Valid read: rdata = word[idx] as it was before this edge.
- Response latency is 1 cycle. rvalid=1 on the cycle after acceptance, for exactly one cycle.
  - Reads: rdata holds the word, err=0.
  - Writes: rdata=0, err=0.
  - Errors: no memory change, rdata=0, err=1.
- When rvalid=0, err=0 and rdata holds its last value.
- A write followed by a read of the same word on the next cycle returns the new data. There is no hazard because the port is single and latency is 1.
- No response backpressure: the consumer must accept every rvalid pulse.
- Reset asserted mid-CLEAR or mid-traffic returns to CLEAR and the clear restarts from word 0.

Optional Feature:
SP_RAM_OUT_REG_EN
- Defined: adds an output register stage after the memory read. Response latency becomes 2 cycles; rvalid, rdata and err are all delayed together. Throughput stays one request per cycle, with up to 2 responses in flight. This variant is intended for BRAM output-register timing closure.
- Not defined: latency is 1 cycle as described above.
- Reset clears both pipeline stages.

Test Plan:
- Reset then idle, DEPTH=16 -> ready=0 for exactly 16 cycles after rstn rises. init_done and ready rise together. Reading addr 0x0..0x3C returns 0 for every word.
- Write addr=0x8, wdata=0xDEADBEEF, wstrb=0xF, then on the next cycle read 0x8 -> write ack has rvalid=1, err=0, rdata=0. Read response has rdata=0xDEADBEEF. Latency is 1 cycle, or 2 with SP_RAM_OUT_REG_EN.
- Partial write to 0x8, wdata=0x11223344, wstrb=0x5 -> read of 0x8 returns 0xDE22BE44.
- Read addr=0x6 (misaligned) and addr=0x40 (out of range) -> each gives rvalid with err=1 and rdata=0. A following read of 0x0 shows memory unchanged.
- Alternate write/read every cycle for 32 cycles to random valid addresses -> exactly one rvalid per request, in order, with data matching a reference model.
- Write 0x8=0xCAFEF00D, pulse rstn low for 1 cycle while a read is in flight -> the in-flight rvalid never appears. A new 16-cycle CLEAR runs, and afterwards a read of 0x8 returns 0.

Source files
------------

// File: rtl/sp_ram_ctrl.sv
// Single-port RAM with req/rsp handshake, byte strobes, address checks and a post-reset clear.
// Define SP_RAM_OUT_REG_EN to add an output register stage (2-cycle response latency).
module sp_ram_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req,
    output logic                ready,
    input  logic                we,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic                init_done
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = (NB > 1) ? $clog2(NB) : 0;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              misaligned;
    logic              out_of_range;
    logic              bad;
    logic [ADDR_W-1:0] word_addr;
    logic [IDX_W-1:0]  idx;

    logic              rv1;
    logic              err1;
    logic [DATA_W-1:0] rd1;

    assign word_addr    = addr >> OFF_W;
    assign misaligned   = |(addr & OFF_MASK);
    assign out_of_range = word_addr >= DEPTH_A;
    assign bad          = misaligned | out_of_range;
    assign accept       = req & ready;
    assign idx          = word_addr[IDX_W-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + IDX_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (cnt == LAST_IDX) state_nxt = IDLE;
            IDLE:    state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        init_done = 1'b0;
        if (state == IDLE) begin
            ready     = 1'b1;
            init_done = 1'b1;
        end
    end

    // Storage has no reset so it maps onto block RAM; the clear sequence zeroes it instead.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (accept && we && !bad) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // rdata keeps its last value between responses; err is only raised alongside rvalid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rv1  <= 1'b0;
            err1 <= 1'b0;
            rd1  <= '0;
        end else if (accept) begin
            rv1  <= 1'b1;
            err1 <= bad;
            rd1  <= (!we && !bad) ? mem[idx] : '0;
        end else begin
            rv1  <= 1'b0;
            err1 <= 1'b0;
        end
    end

`ifdef SP_RAM_OUT_REG_EN
    logic              rv2;
    logic              err2;
    logic [DATA_W-1:0] rd2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rv2  <= 1'b0;
            err2 <= 1'b0;
            rd2  <= '0;
        end else begin
            rv2  <= rv1;
            err2 <= err1;
            if (rv1) begin
                rd2 <= rd1;
            end
        end
    end

    assign rvalid = rv2;
    assign err    = err2;
    assign rdata  = rd2;
`else
    assign rvalid = rv1;
    assign err    = err1;
    assign rdata  = rd1;
`endif

endmodule
